vga_screen_mux: RTL and testbench

Parametrised, frame-synchronous selector for multiple VGA sources: the game board, the win screen, the lose screen and any later overlays. It sits between the VGA pattern generators and the board pins in `overall_2048`, replacing the combinational won/lost multiplexer. Source changes happen only at a vertical-sync boundary, so the monitor never sees a torn frame or a broken sync. The block registers all outputs and can blink non-base screens at a programmable frame rate.

---
 rtl/vga_screen_mux.sv | 182 ++++++++++++++++++
 tb/tb_vga_screen_mux.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_screen_mux.sv
// vga_screen_mux
//   Frame-synchronous selector for several VGA sources (game board, win/lose
//   screens, overlays). The displayed source only changes at the start of a
//   vsync pulse of the current source, so the monitor never sees a torn frame
//   or a broken sync. Non-base sources can blink at a programmable frame rate.
//   All outputs are registered: one dclk of latency for colour and sync alike.
//
// Parameters
//   NSRC          number of sources (2..8); index 0 is the base screen
//   CW            bits per colour channel
//   BLINK_FRAMES  frames per blink half-period (>= 1)
//   VS_ACTIVE_LOW 1: sync pulses are low, 0: sync pulses are high
//
// Ports
//   dclk                      pixel clock
//   clr                       synchronous active-high reset
//   req[NSRC]                 per-source display request, highest index wins
//   blink_en                  blank non-base sources every other half-period
//   red_in/green_in/blue_in   flattened colours, source i at [i*CW +: CW]
//   hsync_in/vsync_in[NSRC]   per-source sync
//   red/green/blue[CW]        registered colour of the selected source
//   hsync/vsync               registered sync of the selected source
//   cur_sel                   index of the source currently being sampled
//   switched                  one-cycle pulse when the new source first shows
module vga_screen_mux #(
  parameter int NSRC          = 3,
  parameter int CW            = 4,
  parameter int BLINK_FRAMES  = 30,
  parameter int VS_ACTIVE_LOW = 1
) (
  input  logic                      dclk,
  input  logic                      clr,
  input  logic [NSRC-1:0]           req,
  input  logic                      blink_en,
  input  logic [NSRC*CW-1:0]        red_in,
  input  logic [NSRC*CW-1:0]        green_in,
  input  logic [NSRC*CW-1:0]        blue_in,
  input  logic [NSRC-1:0]           hsync_in,
  input  logic [NSRC-1:0]           vsync_in,
  output logic [CW-1:0]             red,
  output logic [CW-1:0]             green,
  output logic [CW-1:0]             blue,
  output logic                      hsync,
  output logic                      vsync,
  output logic [$clog2(NSRC)-1:0]   cur_sel,
  output logic                      switched
);

  localparam int SW = $clog2(NSRC);
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  // Level of a sync pulse and the idle level between pulses.
  localparam logic PULSE = (VS_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic IDLE  = ~PULSE;
  localparam logic [FW-1:0] WRAP = FW'(BLINK_FRAMES - 1);

  // Registered state
  logic [SW-1:0] cur_sel_q, cur_sel_d;
  logic          vs_prev_q, vs_prev_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          blink_hide_q, blink_hide_d;
  logic          sw_pend_q, sw_pend_d;
  logic          switched_q, switched_d;
  logic [CW-1:0] red_q, red_d;
  logic [CW-1:0] green_q, green_d;
  logic [CW-1:0] blue_q, blue_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;

  // Combinational helpers
  logic [CW-1:0] src_r_s, src_g_s, src_b_s;
  logic          src_hs_s, src_vs_s;
  logic [SW-1:0] target_s;
  logic          fe_s;
  logic          switch_s;
  logic          hide_s;

  // Source multiplexer: pick colour and sync of the currently selected source.
  always_comb begin
    src_r_s  = '0;
    src_g_s  = '0;
    src_b_s  = '0;
    src_hs_s = IDLE;
    src_vs_s = IDLE;
    for (int i = 0; i < NSRC; i++) begin
      src_r_s  = (cur_sel_q == SW'(i)) ? red_in[i*CW +: CW]   : src_r_s;
      src_g_s  = (cur_sel_q == SW'(i)) ? green_in[i*CW +: CW] : src_g_s;
      src_b_s  = (cur_sel_q == SW'(i)) ? blue_in[i*CW +: CW]  : src_b_s;
      src_hs_s = (cur_sel_q == SW'(i)) ? hsync_in[i]          : src_hs_s;
      src_vs_s = (cur_sel_q == SW'(i)) ? vsync_in[i]          : src_vs_s;
    end
  end

  // Priority encoder: highest requesting index, base screen when none.
  always_comb begin
    target_s = '0;
    for (int i = 1; i < NSRC; i++) begin
      target_s = req[i] ? SW'(i) : target_s;
    end
  end

  // Frame edge, switch decision and blanking condition.
  always_comb begin
    fe_s     = (src_vs_s == PULSE) && (vs_prev_q != PULSE);
    switch_s = fe_s && (target_s != cur_sel_q);
    hide_s   = blink_en && blink_hide_q && (cur_sel_q != '0);
  end

  // Next-state logic for selection, blink counter and output pipeline.
  always_comb begin
    cur_sel_d    = cur_sel_q;
    vs_prev_d    = src_vs_s;
    fcnt_d       = fcnt_q;
    blink_hide_d = blink_hide_q;
    // The new source is sampled one cycle after the switch and shows one
    // cycle later still, so the pulse is delayed through sw_pend.
    sw_pend_d    = switch_s;
    switched_d   = sw_pend_q;

    if (switch_s) begin
      // A switch restarts the blink phase so every new screen starts visible.
      cur_sel_d    = target_s;
      fcnt_d       = '0;
      blink_hide_d = 1'b0;
    end else if (fe_s) begin
      if (fcnt_q == WRAP) begin
        fcnt_d       = '0;
        blink_hide_d = ~blink_hide_q;
      end else begin
        fcnt_d       = fcnt_q + FW'(1);
        blink_hide_d = blink_hide_q;
      end
    end else begin
      fcnt_d       = fcnt_q;
      blink_hide_d = blink_hide_q;
    end

    // Sync is never blanked so the monitor keeps lock while blinking.
    red_d   = hide_s ? '0 : src_r_s;
    green_d = hide_s ? '0 : src_g_s;
    blue_d  = hide_s ? '0 : src_b_s;
    hsync_d = src_hs_s;
    vsync_d = src_vs_s;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge dclk) begin
    if (clr) begin
      cur_sel_q    <= '0;
      vs_prev_q    <= IDLE;
      fcnt_q       <= '0;
      blink_hide_q <= 1'b0;
      sw_pend_q    <= 1'b0;
      switched_q   <= 1'b0;
      red_q        <= '0;
      green_q      <= '0;
      blue_q       <= '0;
      hsync_q      <= IDLE;
      vsync_q      <= IDLE;
    end else begin
      cur_sel_q    <= cur_sel_d;
      vs_prev_q    <= vs_prev_d;
      fcnt_q       <= fcnt_d;
      blink_hide_q <= blink_hide_d;
      sw_pend_q    <= sw_pend_d;
      switched_q   <= switched_d;
      red_q        <= red_d;
      green_q      <= green_d;
      blue_q       <= blue_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
    end
  end

  assign red      = red_q;
  assign green    = green_q;
  assign blue     = blue_q;
  assign hsync    = hsync_q;
  assign vsync    = vsync_q;
  assign cur_sel  = cur_sel_q;
  assign switched = switched_q;

endmodule

// File: tb/tb_vga_screen_mux.sv
// Testbench for vga_screen_mux.
// A shared miniature timing generator (16-cycle lines, 128-cycle frames,
// vsync pulse on the first line) feeds three sources with random colour.
// A behavioural reference pushes the expected output word for every cycle
// into a queue when inputs are driven; the word is popped and compared one
// edge later. A second instance with positive sync pulses sees the inverted
// syncs and is compared against the same expectation with syncs inverted.
module tb_vga_screen_mux;

  localparam int NSRC  = 3;
  localparam int CW    = 4;
  localparam int BF    = 2;
  localparam int LINE  = 16;
  localparam int FRAME = 128;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic blink_en = 1'b0;
  logic [2:0] req = 3'b000;

  logic [3:0] r_src [3] = '{4'h1, 4'h1, 4'h1};
  logic [3:0] g_src [3] = '{4'h0, 4'h0, 4'h0};
  logic [3:0] b_src [3] = '{4'h0, 4'h0, 4'h0};
  logic hs_c = 1'b1;
  logic vs_c = 1'b1;
  int   pix  = 100;

  logic [11:0] red_in, green_in, blue_in;
  logic [2:0]  hsync_in, vsync_in, hsync_in_p, vsync_in_p;

  logic [3:0] red, green, blue, red_p, green_p, blue_p;
  logic       hsync, vsync, hsync_p, vsync_p;
  logic [1:0] cur_sel, cur_sel_p;
  logic       switched, switched_p;

  assign red_in     = {r_src[2], r_src[1], r_src[0]};
  assign green_in   = {g_src[2], g_src[1], g_src[0]};
  assign blue_in    = {b_src[2], b_src[1], b_src[0]};
  assign hsync_in   = {3{hs_c}};
  assign vsync_in   = {3{vs_c}};
  assign hsync_in_p = ~hsync_in;
  assign vsync_in_p = ~vsync_in;

  vga_screen_mux #(.NSRC(NSRC), .CW(CW), .BLINK_FRAMES(BF), .VS_ACTIVE_LOW(1)) dut (
    .dclk(clk), .clr(clr), .req(req), .blink_en(blink_en),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync),
    .cur_sel(cur_sel), .switched(switched)
  );

  vga_screen_mux #(.NSRC(NSRC), .CW(CW), .BLINK_FRAMES(BF), .VS_ACTIVE_LOW(0)) dut_p (
    .dclk(clk), .clr(clr), .req(req), .blink_en(blink_en),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .hsync_in(hsync_in_p), .vsync_in(vsync_in_p),
    .red(red_p), .green(green_p), .blue(blue_p), .hsync(hsync_p), .vsync(vsync_p),
    .cur_sel(cur_sel_p), .switched(switched_p)
  );

  initial begin
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected word: {red, green, blue, hsync, vsync, cur_sel, switched}
  logic [16:0] exp_q [$];
  bit          started = 1'b0;

  // Reference state (active-low sync domain)
  logic [1:0] m_sel;
  logic       m_prev, m_hide, m_pend;
  int         m_cnt;

  task automatic model_step();
    logic [16:0] e;
    logic        fe;
    logic [1:0]  tgt;
    logic        blank;
    if (clr) begin
      e      = {12'h000, 1'b1, 1'b1, 2'd0, 1'b0};
      m_sel  = 2'd0;
      m_prev = 1'b1;
      m_cnt  = 0;
      m_hide = 1'b0;
      m_pend = 1'b0;
    end else begin
      fe    = (vs_c == 1'b0) && (m_prev == 1'b1);
      tgt   = req[2] ? 2'd2 : (req[1] ? 2'd1 : 2'd0);
      blank = blink_en && m_hide && (m_sel != 2'd0);
      e[16:5] = blank ? 12'h000 : {r_src[m_sel], g_src[m_sel], b_src[m_sel]};
      e[4]    = hs_c;
      e[3]    = vs_c;
      e[2:1]  = (fe && (tgt != m_sel)) ? tgt : m_sel;
      e[0]    = m_pend;
      m_pend  = fe && (tgt != m_sel);
      if (m_pend) begin
        m_cnt  = 0;
        m_hide = 1'b0;
        m_sel  = tgt;
      end else if (fe) begin
        if (m_cnt == BF - 1) begin
          m_cnt  = 0;
          m_hide = ~m_hide;
        end else begin
          m_cnt++;
        end
      end
      m_prev = vs_c;
    end
    exp_q.push_back(e);
    started = 1'b1;
  endtask

  // Drive the next pixel on the falling edge and record its expectation.
  always @(negedge clk) begin
    pix = (pix + 1) % FRAME;
    for (int i = 0; i < NSRC; i++) begin
      r_src[i] = 4'($urandom) | 4'h1;
      g_src[i] = 4'($urandom);
      b_src[i] = 4'($urandom);
    end
    hs_c = ((pix % LINE) < 2) ? 1'b0 : 1'b1;
    vs_c = (pix < LINE) ? 1'b0 : 1'b1;
    model_step();
  end

  logic [16:0] e_chk;

  // Pop and compare one expectation per clock edge for both instances.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e_chk = exp_q.pop_front();
      check_eq("out", 32'({red, green, blue, hsync, vsync, cur_sel, switched}), 32'(e_chk));
      check_eq("pol", 32'({red_p, green_p, blue_p, hsync_p, vsync_p, cur_sel_p, switched_p}),
               32'(e_chk ^ 17'h00018));
    end else if (started) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end
  end

  // Return at posedge+2 of the edge that registered pixel p.
  task automatic wait_pix(input int p);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while ((pix != p) && (n < 2 * FRAME));
    if (pix != p) check_eq("wait_pix_timeout", 32'd0, 32'd1);
  endtask

  // Return at posedge+1 of the first edge where cur_sel equals s.
  task automatic wait_sel(input string tag, input logic [1:0] s, output int at_pix);
    int n;
    n = 0;
    at_pix = -1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while ((cur_sel != s) && (n < 3 * FRAME));
    if (cur_sel == s) at_pix = pix;
    else check_eq({tag, "_timeout"}, 32'(cur_sel), 32'(s));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    int bad;

    // Reset held for three edges with toggling inputs
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rgb",   32'({red, green, blue}), 32'd0);
    check_eq("rst_hs",    32'(hsync), 32'd1);
    check_eq("rst_vs",    32'(vsync), 32'd1);
    check_eq("rst_sel",   32'(cur_sel), 32'd0);
    check_eq("rst_sw",    32'(switched), 32'd0);
    check_eq("rst_hs_p",  32'(hsync_p), 32'd0);
    check_eq("rst_vs_p",  32'(vsync_p), 32'd0);
    #1 clr = 1'b0;
    repeat (2 * FRAME) @(posedge clk);

    // Frame-aligned switch requested mid-frame
    wait_pix(60);
    req = 3'b010;
    wait_sel("sw1", 2'd1, p);
    check_eq("sw1_edge", 32'(p), 32'd0);
    @(posedge clk);
    #1;
    check_eq("sw1_pulse", 32'(switched), 32'd1);
    @(posedge clk);
    #1;
    check_eq("sw1_pulse_end", 32'(switched), 32'd0);

    // Priority: source 2 beats source 1, then back to base
    #1 req = 3'b110;
    wait_sel("pri", 2'd2, p);
    check_eq("pri_edge", 32'(p), 32'd0);
    #1 req = 3'b000;
    wait_sel("back0", 2'd0, p);
    check_eq("back0_edge", 32'(p), 32'd0);

    // Request glitch inside one frame never switches
    wait_pix(20);
    req = 3'b010;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (cur_sel != 2'd0) bad++;
    end
    #1 req = 3'b000;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(posedge clk);
      #1;
      if (cur_sel != 2'd0) bad++;
    end
    check_eq("glitch", 32'(bad), 32'd0);

    // Blink: two frames visible, two hidden, syncs untouched
    #1 blink_en = 1'b1;
    req = 3'b010;
    wait_sel("blk", 2'd1, p);
    check_eq("blk_edge", 32'(p), 32'd0);
    for (int f = 0; f < 6; f++) begin
      wait_pix(64);
      check_eq("blk_vis", 32'({red, green, blue} != 12'h000), 32'(((f / 2) % 2) == 0));
      wait_pix(0);
      check_eq("blk_sync", 32'({hsync, vsync}), 32'd0);
    end
    req = 3'b000;
    wait_sel("blk_back", 2'd0, p);
    for (int f = 0; f < 3; f++) begin
      wait_pix(64);
      check_eq("base_vis", 32'({red, green, blue} != 12'h000), 32'd1);
    end

    // Reset while source 2 is selected and hidden
    req = 3'b100;
    wait_sel("r2", 2'd2, p);
    wait_pix(64);
    wait_pix(64);
    wait_pix(64);
    check_eq("r2_hidden", 32'({red, green, blue}), 32'd0);
    clr = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid_rst_sel", 32'(cur_sel), 32'd0);
    check_eq("mid_rst_rgb", 32'({red, green, blue}), 32'd0);
    check_eq("mid_rst_hs",  32'(hsync), 32'd1);
    #1 clr = 1'b0;
    wait_sel("r2_back", 2'd2, p);
    check_eq("r2_back_edge", 32'(p), 32'd0);
    wait_pix(64);
    check_eq("r2_vis", 32'({red, green, blue} != 12'h000), 32'd1);

    req = 3'b000;
    repeat (20) @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
